// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, special register IDs and status codes.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RRSP  = 4'h4;
  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SHLT = 3'd2;
  localparam logic [2:0] SADR = 3'd3;
  localparam logic [2:0] SINS = 3'd4;

endpackage

// File: rtl/wb_dest_sel.sv
// Write-back destination selection: maps (icode, rA, rB, cnd) to the E and M
// destination register IDs; RNONE means no write on that port.
module wb_dest_sel
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] rA,
  input  logic [3:0] rB,
  input  logic       cnd,
  output logic [3:0] dstE,
  output logic [3:0] dstM
);

  always_comb begin
    dstE = RNONE;
    case (icode)
      IRRMOVQ:                      dstE = cnd ? rB : RNONE;
      IIRMOVQ, IOPQ:                dstE = rB;
      ICALL, IRET, IPUSHQ, IPOPQ:   dstE = RRSP;
      default:                      dstE = RNONE;
    endcase
  end

  always_comb begin
    dstM = RNONE;
    case (icode)
      IMRMOVQ, IPOPQ: dstM = rA;
      default:        dstM = RNONE;
    endcase
  end

endmodule

// File: rtl/writeback_regfile.sv
// Y86-64 write-back stage: architectural register file, dual-port commit and
// RUN/STOP status FSM. Optional retired-instruction counter under WB_RETIRE_CNT_EN.
module writeback_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_RESET = 64'd0,
  parameter int          NREGS     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  rA,
  input  logic [3:0]  rB,
  input  logic        cnd,
  input  logic [63:0] valE,
  input  logic [63:0] valM,
  input  logic        mem_error,
  output logic [63:0] reg0,
  output logic [63:0] reg1,
  output logic [63:0] reg2,
  output logic [63:0] reg3,
  output logic [63:0] reg4,
  output logic [63:0] reg5,
  output logic [63:0] reg6,
  output logic [63:0] reg7,
  output logic [63:0] reg8,
  output logic [63:0] reg9,
  output logic [63:0] reg10,
  output logic [63:0] reg11,
  output logic [63:0] reg12,
  output logic [63:0] reg13,
  output logic [63:0] reg14,
  output logic [2:0]  stat,
  output logic        halted
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0] retired
`endif
);

  typedef enum logic {RUN, STOP} state_t;

  state_t      state, state_nx;
  logic [2:0]  stat_nx;
  logic [63:0] regs [NREGS];
  logic [3:0]  dstE, dstM;
  logic        stop_now, commit, we_e, we_m;

  wb_dest_sel u_dest_sel (
    .icode (icode),
    .rA    (rA),
    .rB    (rB),
    .cnd   (cnd),
    .dstE  (dstE),
    .dstM  (dstM)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      stat  <= SAOK;
    end else begin
      state <= state_nx;
      stat  <= stat_nx;
    end
  end

  // Fault priority ADR > INS > HLT; STOP only exits via reset.
  always_comb begin
    state_nx = state;
    stat_nx  = stat;
    stop_now = 1'b0;
    if (state == RUN && wb_valid) begin
      if (mem_error) begin
        stop_now = 1'b1;
        stat_nx  = SADR;
      end else if (icode > IPOPQ) begin
        stop_now = 1'b1;
        stat_nx  = SINS;
      end else if (icode == IHALT) begin
        stop_now = 1'b1;
        stat_nx  = SHLT;
      end
      if (stop_now) state_nx = STOP;
    end
  end

  assign commit = (state == RUN) && wb_valid && !stop_now;
  assign we_e   = commit && (dstE != RNONE);
  assign we_m   = commit && (dstM != RNONE);

  // The M write is applied after E so it wins when both target the same register.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= (4'(i) == RRSP) ? RSP_RESET : 64'd0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (we_e && dstE == 4'(i)) regs[i] <= valE;
        if (we_m && dstM == 4'(i)) regs[i] <= valM;
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)         retired <= 64'd0;
    else if (commit) retired <= retired + 64'd1;
  end
`endif

  assign halted = (stat != SAOK);

  assign reg0  = regs[0];
  assign reg1  = regs[1];
  assign reg2  = regs[2];
  assign reg3  = regs[3];
  assign reg4  = regs[4];
  assign reg5  = regs[5];
  assign reg6  = regs[6];
  assign reg7  = regs[7];
  assign reg8  = regs[8];
  assign reg9  = regs[9];
  assign reg10 = regs[10];
  assign reg11 = regs[11];
  assign reg12 = regs[12];
  assign reg13 = regs[13];
  assign reg14 = regs[14];

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, writes, cmov gating, popq
// collision, halt freeze, fault codes/priority and (optionally) retired count.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst, wb_valid, cnd, mem_error;
  logic [3:0]  icode, rA, rB;
  logic [63:0] valE, valM;
  logic [63:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14;
  logic [2:0]  stat;
  logic        halted;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retired;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_regfile #(.RSP_RESET(64'h100), .NREGS(15)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .icode(icode), .rA(rA), .rB(rB),
    .cnd(cnd), .valE(valE), .valM(valM), .mem_error(mem_error),
    .reg0(r0), .reg1(r1), .reg2(r2), .reg3(r3), .reg4(r4), .reg5(r5), .reg6(r6),
    .reg7(r7), .reg8(r8), .reg9(r9), .reg10(r10), .reg11(r11), .reg12(r12),
    .reg13(r13), .reg14(r14), .stat(stat), .halted(halted)
`ifdef WB_RETIRE_CNT_EN
    , .retired(retired)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample #1 after the edge.
  task automatic step(input logic r, input logic v, input logic [3:0] ic,
                      input logic [3:0] a, input logic [3:0] b, input logic c,
                      input logic [63:0] e, input logic [63:0] m, input logic me);
    rst = r; wb_valid = v; icode = ic; rA = a; rB = b; cnd = c;
    valE = e; valM = m; mem_error = me;
    @(posedge clk);
    #1;
    rst = 1'b0; wb_valid = 1'b0; mem_error = 1'b0;
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 4'h1, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
  endtask

  initial begin
    rst = 1'b0; wb_valid = 1'b0; icode = 4'h1; rA = 4'hF; rB = 4'hF;
    cnd = 1'b0; valE = '0; valM = '0; mem_error = 1'b0;
    @(negedge clk);

    // reset with a concurrent irmovq: reset wins
    step(1'b1, 1'b1, 4'h3, 4'hF, 4'h9, 1'b0, 64'hDEAD, 64'd0, 1'b0);
    check("rst_reg4", r4, 64'h100);
    check("rst_reg9", r9, 64'd0);
    check("rst_reg0", r0, 64'd0);
    check("rst_reg14", r14, 64'd0);
    check("rst_stat", {61'd0, stat}, 64'd1);
    check("rst_halted", {63'd0, halted}, 64'd0);

    // irmovq rB=9, then rB=F
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'h9, 1'b0, 64'h1234, 64'd0, 1'b0);
    check("irmovq_reg9", r9, 64'h1234);
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'hF, 1'b0, 64'h5555, 64'd0, 1'b0);
    check("irmovq_none_reg9", r9, 64'h1234);
    check("irmovq_none_reg0", r0, 64'd0);
    check("irmovq_none_reg14", r14, 64'd0);

    // cmov gated by cnd
    step(1'b0, 1'b1, 4'h2, 4'hF, 4'h3, 1'b0, 64'd7, 64'd0, 1'b0);
    check("cmov_cnd0_reg3", r3, 64'd0);
    step(1'b0, 1'b1, 4'h2, 4'hF, 4'h3, 1'b1, 64'd7, 64'd0, 1'b0);
    check("cmov_cnd1_reg3", r3, 64'd7);

    // popq %rsp: valM wins; then popq %rdx
    step(1'b0, 1'b1, 4'hB, 4'h4, 4'hF, 1'b0, 64'h108, 64'hABC, 1'b0);
    check("popq_rsp_reg4", r4, 64'hABC);
    step(1'b0, 1'b1, 4'hB, 4'h2, 4'hF, 1'b0, 64'h110, 64'd5, 1'b0);
    check("popq_reg2", r2, 64'd5);
    check("popq_reg4", r4, 64'h110);

    // wb_valid low: nothing happens
    step(1'b0, 1'b0, 4'h3, 4'hF, 4'h5, 1'b0, 64'h77, 64'd0, 1'b0);
    check("novalid_reg5", r5, 64'd0);
    check("novalid_stat", {61'd0, stat}, 64'd1);

    // call writes rsp from valE; mrmovq writes rA from valM
    step(1'b0, 1'b1, 4'h8, 4'hF, 4'hF, 1'b0, 64'hF8, 64'd0, 1'b0);
    check("call_reg4", r4, 64'hF8);
    step(1'b0, 1'b1, 4'h5, 4'h7, 4'hF, 1'b0, 64'h40, 64'h99, 1'b0);
    check("mrmovq_reg7", r7, 64'h99);

    // halt, then frozen
    step(1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b0);
    check("halt_stat", {61'd0, stat}, 64'd2);
    check("halt_halted", {63'd0, halted}, 64'd1);
`ifdef WB_RETIRE_CNT_EN
    check("halt_retired", retired, 64'd8);
`endif
    step(1'b0, 1'b1, 4'h3, 4'hF, 4'h1, 1'b0, 64'd9, 64'd0, 1'b0);
    check("frozen_reg1", r1, 64'd0);
    step(1'b0, 1'b1, 4'h5, 4'h6, 4'hF, 1'b0, 64'd0, 64'd1, 1'b1);
    check("frozen_stat", {61'd0, stat}, 64'd2);
`ifdef WB_RETIRE_CNT_EN
    check("frozen_retired", retired, 64'd8);
`endif
    do_reset();
    check("rerst_stat", {61'd0, stat}, 64'd1);
    check("rerst_halted", {63'd0, halted}, 64'd0);
    check("rerst_reg9", r9, 64'd0);
    check("rerst_reg4", r4, 64'h100);

    // address fault on mrmovq
    step(1'b0, 1'b1, 4'h6, 4'hF, 4'h6, 1'b0, 64'h33, 64'd0, 1'b0);
    check("opq_reg6", r6, 64'h33);
    step(1'b0, 1'b1, 4'h5, 4'h6, 4'hF, 1'b0, 64'h10, 64'h77, 1'b1);
    check("adr_reg6", r6, 64'h33);
    check("adr_stat", {61'd0, stat}, 64'd3);
`ifdef WB_RETIRE_CNT_EN
    check("adr_retired", retired, 64'd1);
`endif

    // invalid instruction
    do_reset();
    step(1'b0, 1'b1, 4'hC, 4'h1, 4'h1, 1'b0, 64'h5, 64'h6, 1'b0);
    check("ins_stat", {61'd0, stat}, 64'd4);
    check("ins_reg1", r1, 64'd0);

    // priority: ADR over HLT, ADR over INS, INS over nothing else
    do_reset();
    step(1'b0, 1'b1, 4'h0, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
    check("prio_adr_hlt", {61'd0, stat}, 64'd3);
    do_reset();
    step(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0, 64'd0, 64'd0, 1'b1);
    check("prio_adr_ins", {61'd0, stat}, 64'd3);

    // popq with faulting address commits neither port
    do_reset();
    step(1'b0, 1'b1, 4'hB, 4'h2, 4'hF, 1'b0, 64'h108, 64'h55, 1'b1);
    check("popq_fault_reg2", r2, 64'd0);
    check("popq_fault_reg4", r4, 64'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
